pipe_scroller: RTL and testbench

- Consumes the free-running pseudo-random gap value (0..348) and turns it into a scrolling set of pipe obstacles.
- Owns a small ring of pipe slots. Each slot holds a right-edge x position, a gap-top y value and a valid bit.
- On each frame tick it advances every pipe leftward, retires pipes that leave the screen, spawns new pipes at a fixed cadence, and pulses score when a pipe passes the bird.
- Feeds the VGA renderer and the collision checker downstream.

---
 rtl/flappy_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 72 +++++++
 rtl/pipe_scroller.sv | 114 +++++++++++
 tb/tb_pipe_scroller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and helpers for the flappy game pipeline.
package flappy_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIPE_W   = 80;
    localparam int GAP_H    = 90;
    localparam int X_W      = 11;
    localparam int GAP_W    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_e;

    // Clamp the raw random value into [0, rnd_max-1] and offset it to a gap-top y.
    function automatic logic [GAP_W-1:0] clamp_gap(input logic [GAP_W-1:0] rnd,
                                                   input int rnd_max,
                                                   input int margin);
        logic [GAP_W-1:0] v;
        v = (int'(rnd) >= rnd_max) ? GAP_W'(rnd_max - 1) : rnd;
        return v + GAP_W'(margin);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe obstacle: right-edge x, gap-top y and a valid flag.
// Moves left on each processed frame, retires when it reaches the screen edge.
module pipe_slot
    import flappy_pkg::*;
#(
    parameter int SPEED  = 2,
    parameter int BIRD_X = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [X_W-1:0]   load_x,
    input  logic [GAP_W-1:0] load_gap,
    input  logic             move,
    output logic [X_W-1:0]   x,
    output logic [GAP_W-1:0] gap,
    output logic             valid,
    output logic             crossed
);

    localparam logic [X_W-1:0] SPEED_X = X_W'(SPEED);
    localparam logic [X_W-1:0] BIRD_XX = X_W'(BIRD_X);

    logic [X_W-1:0]   x_q, x_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             valid_q, valid_d;
    logic             retire;
    logic [X_W-1:0]   x_moved;

    // Next-state: clear beats load beats move; a retiring pipe keeps its x.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        x_d     = x_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        retire  = valid_q && (x_q <= SPEED_X);
        x_moved = x_q - SPEED_X;
        crossed = move && valid_q && !retire && (x_q >= BIRD_XX) && (x_moved < BIRD_XX);
        if (clear) begin
            x_d     = '0;
            gap_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            x_d     = load_x;
            gap_d   = load_gap;
            valid_d = 1'b1;
        end else if (move && valid_q) begin
            if (retire) valid_d = 1'b0;
            else        x_d     = x_moved;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            x_q     <= x_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
        end
    end

    assign x     = x_q;
    assign gap   = gap_q;
    assign valid = valid_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe obstacle manager: run/freeze FSM, spawn cadence, slot ring
// write pointer and the registered score pulse.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES      = 3,
    parameter int SPEED          = 2,
    parameter int SPAWN_INTERVAL = 120,
    parameter int SPAWN_X        = 720,
    parameter int BIRD_X         = 200,
    parameter int GAP_MARGIN     = 40,
    parameter int RND_MAX        = 349
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       crash,
    input  logic [9:0]                 rnd,
    output logic [NUM_PIPES*X_W-1:0]   pipe_x,
    output logic [NUM_PIPES*GAP_W-1:0] pipe_gap,
    output logic [NUM_PIPES-1:0]       pipe_valid,
    output logic                       score_pulse,
    output logic                       running
);

    localparam int PTR_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);

    state_e               state_q;
    logic [CNT_W-1:0]     spawn_cnt_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 score_q, running_q;

    logic                 run_tick, spawn_now, clear_slots;
    logic [NUM_PIPES-1:0] load_vec, crossed_vec;
    logic [GAP_W-1:0]     gap_new;

    // A crash in RUN overrides start; a start overrides a tick in the same cycle.
    assign run_tick    = (state_q == RUN) && tick && !crash && !start;
    assign clear_slots = start && !((state_q == RUN) && crash);
    assign spawn_now   = run_tick && (spawn_cnt_q == '0);
    assign gap_new     = clamp_gap(rnd, RND_MAX, GAP_MARGIN);
    assign wr_ptr_d    = (wr_ptr_q == PTR_W'(NUM_PIPES - 1)) ? '0 : wr_ptr_q + 1'b1;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
        logic busy;
        // Slot stays occupied only if it survives this tick's retire check.
        assign busy        = pipe_valid[i] && (pipe_x[X_W*i +: X_W] > X_W'(SPEED));
        assign load_vec[i] = spawn_now && (wr_ptr_q == PTR_W'(i)) && !busy;

        pipe_slot #(
            .SPEED  (SPEED),
            .BIRD_X (BIRD_X)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear_slots),
            .load     (load_vec[i]),
            .load_x   (X_W'(SPAWN_X)),
            .load_gap (gap_new),
            .move     (run_tick),
            .x        (pipe_x[X_W*i +: X_W]),
            .gap      (pipe_gap[GAP_W*i +: GAP_W]),
            .valid    (pipe_valid[i]),
            .crossed  (crossed_vec[i])
        );
    end

    // Run/freeze FSM with spawn cadence, ring pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            spawn_cnt_q <= '0;
            wr_ptr_q    <= '0;
            score_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            score_q <= 1'b0;
            case (state_q)
                IDLE, FROZEN: begin
                    if (start) begin
                        state_q     <= RUN;
                        running_q   <= 1'b1;
                        spawn_cnt_q <= '0;
                        wr_ptr_q    <= '0;
                    end
                end
                RUN: begin
                    if (crash) begin
                        state_q   <= FROZEN;
                        running_q <= 1'b0;
                    end else if (start) begin
                        spawn_cnt_q <= '0;
                        wr_ptr_q    <= '0;
                    end else if (run_tick) begin
                        spawn_cnt_q <= (spawn_cnt_q == '0) ? CNT_W'(SPAWN_INTERVAL - 1)
                                                           : spawn_cnt_q - 1'b1;
                        if (|load_vec) wr_ptr_q <= wr_ptr_d;
                        score_q <= |crossed_vec;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign score_pulse = score_q;
    assign running     = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: default instance plus a short-interval
// instance driven by the same stimulus, both checked against a tick-age model.
module tb_pipe_scroller;

    localparam int N       = 3;
    localparam int XW      = 11;
    localparam int GW      = 10;
    localparam int SPAWN_X = 720;
    localparam int SPEED   = 2;
    localparam int BIRD_X  = 200;
    localparam int MOVES   = (SPAWN_X - 1) / SPEED;   // moves before a pipe retires
    localparam int IVAL [2] = '{120, 10};

    typedef struct packed {
        logic [N*XW-1:0] x;
        logic [N*GW-1:0] gap;
        logic [N-1:0]    valid;
        logic            score;
        logic            running;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, tick, start, crash;
    logic [9:0] rnd;

    logic [N*XW-1:0] a_x, b_x;
    logic [N*GW-1:0] a_gap, b_gap;
    logic [N-1:0]    a_valid, b_valid;
    logic            a_score, b_score, a_run, b_run;

    always #5 clk = ~clk;

    pipe_scroller u_dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .crash(crash), .rnd(rnd),
        .pipe_x(a_x), .pipe_gap(a_gap), .pipe_valid(a_valid),
        .score_pulse(a_score), .running(a_run)
    );

    pipe_scroller #(.SPAWN_INTERVAL(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .crash(crash), .rnd(rnd),
        .pipe_x(b_x), .pipe_gap(b_gap), .pipe_valid(b_valid),
        .score_pulse(b_score), .running(b_run)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 run, 2 frozen. A slot remembers the run-tick index it was
    // spawned on (-1 = cleared); its position follows from its age in ticks.
    int m_mode [2];
    int m_t    [2];
    int m_ptr  [2];
    int m_s    [2][N];
    int m_gap  [2][N];
    bit m_score[2];

    function automatic int x_at(int age);
        if (age <= MOVES) return SPAWN_X - age * SPEED;
        return SPAWN_X - MOVES * SPEED;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_mode[v] = 0; m_t[v] = 0; m_ptr[v] = 0; m_score[v] = 1'b0;
            for (int i = 0; i < N; i++) begin m_s[v][i] = -1; m_gap[v][i] = 0; end
        end
    endtask

    task automatic model_step(input int v, input bit t, input bit s, input bit c, input int r);
        int tn, p, a;
        m_score[v] = 1'b0;
        if (m_mode[v] == 1 && c) begin
            m_mode[v] = 2;
        end else if (s) begin
            m_mode[v] = 1; m_t[v] = 0; m_ptr[v] = 0;
            for (int i = 0; i < N; i++) begin m_s[v][i] = -1; m_gap[v][i] = 0; end
        end else if (m_mode[v] == 1 && t) begin
            tn = m_t[v];
            for (int i = 0; i < N; i++) begin
                if (m_s[v][i] >= 0) begin
                    a = tn - m_s[v][i];
                    if (x_at(a - 1) >= BIRD_X && x_at(a) < BIRD_X) m_score[v] = 1'b1;
                end
            end
            if (tn % IVAL[v] == 0) begin
                p = m_ptr[v];
                if (m_s[v][p] < 0 || (tn - m_s[v][p]) > MOVES) begin
                    m_s[v][p]   = tn;
                    m_gap[v][p] = ((r > 348) ? 348 : r) + 40;
                    m_ptr[v]    = (p + 1) % N;
                end
            end
            m_t[v] = tn + 1;
        end
    endtask

    function automatic exp_t expect_of(input int v);
        exp_t e;
        int a;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (m_s[v][i] >= 0) begin
                a = m_t[v] - 1 - m_s[v][i];
                e.x[XW*i +: XW]   = XW'(x_at(a));
                e.gap[GW*i +: GW] = GW'(m_gap[v][i]);
                e.valid[i]        = (a <= MOVES);
            end
        end
        e.score   = m_score[v];
        e.running = (m_mode[v] == 1);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    // Monitor: each clock the DUTs present a new output set; compare it with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && q_a.size() > 0 && q_b.size() > 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check("a.pipe_x",   64'(a_x),     64'(ea.x));
            check("a.pipe_gap", 64'(a_gap),   64'(ea.gap));
            check("a.valid",    64'(a_valid), 64'(ea.valid));
            check("a.score",    64'(a_score), 64'(ea.score));
            check("a.running",  64'(a_run),   64'(ea.running));
            check("b.pipe_x",   64'(b_x),     64'(eb.x));
            check("b.pipe_gap", 64'(b_gap),   64'(eb.gap));
            check("b.valid",    64'(b_valid), 64'(eb.valid));
            check("b.score",    64'(b_score), 64'(eb.score));
            check("b.running",  64'(b_run),   64'(eb.running));
        end
    end

    // Apply one cycle of stimulus and queue what both DUTs must show after the edge.
    task automatic drive(input bit t, input bit s, input bit c, input logic [9:0] r);
        @(negedge clk);
        tick = t; start = s; crash = c; rnd = r;
        for (int v = 0; v < 2; v++) model_step(v, t, s, c, int'(r));
        q_a.push_back(expect_of(0));
        q_b.push_back(expect_of(1));
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".x0"},    64'({a_x, b_x}),         64'(0));
        check({tag, ".gap0"},  64'({a_gap, b_gap}),     64'(0));
        check({tag, ".val0"},  64'({a_valid, b_valid}), 64'(0));
        check({tag, ".flag0"}, 64'({a_score, b_score, a_run, b_run}), 64'(0));
    endtask

    // Watchdog: the stimulus is finite, but never let a broken run hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] r;
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; crash = 1'b0; rnd = '0;
        model_reset();
        #3;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive(0, 0, 0, 10'd5);
        drive(1, 0, 0, 10'd5);            // tick in IDLE does nothing
        drive(0, 1, 0, 10'd0);            // start

        // Long run: 1000 ticks with random spacing and random gap values.
        for (int k = 0; k < 1000; k++) begin
            r = (k == 0) ? 10'd100 : (k == 120) ? 10'd500 : 10'($urandom_range(0, 1023));
            drive(1, 0, 0, r);
            if (k == 0) begin
                check("first.x0",   64'(a_x[10:0]),  64'(720));
                check("first.gap0", 64'(a_gap[9:0]), 64'(140));
                check("first.val",  64'(a_valid),    64'(3'b001));
                check("first.run",  64'(a_run),      64'(1));
            end
            if (k == 30) begin
                check("skip.b_val", 64'(b_valid),    64'(3'b111));
                check("skip.b_x0",  64'(b_x[10:0]),  64'(660));
            end
            if (k == 120) begin
                check("clamp.val",  64'(a_valid),     64'(3'b011));
                check("clamp.gap1", 64'(a_gap[19:10]), 64'(388));
            end
            if (k == 260) begin
                check("bird.x200",  64'(a_x[10:0]), 64'(200));
                check("bird.noscr", 64'(a_score),   64'(0));
            end
            if (k == 261) begin
                check("bird.x198",  64'(a_x[10:0]), 64'(198));
                check("bird.score", 64'(a_score),   64'(1));
            end
            if (k == 360) begin
                check("respawn.x0", 64'(a_x[10:0]), 64'(720));
                check("respawn.v0", 64'(a_valid[0]), 64'(1));
            end
            repeat ($urandom_range(0, 1)) drive(0, 0, 0, 10'($urandom_range(0, 1023)));
        end

        // Crash with a simultaneous tick: freeze, tick ignored.
        drive(1, 0, 1, 10'd3);
        check("crash.run", 64'(a_run), 64'(0));
        repeat (4) drive(1, 0, 0, 10'd9);
        check("frozen.run", 64'(a_run), 64'(0));

        // Restart from FROZEN.
        drive(0, 1, 0, 10'd0);
        check("restart.val", 64'(a_valid), 64'(0));
        check("restart.run", 64'(a_run),   64'(1));
        drive(1, 0, 0, 10'd77);
        check("restart.gap", 64'(a_gap[9:0]), 64'(117));
        check("restart.x0",  64'(a_x[10:0]),  64'(720));
        repeat (5) drive(1, 0, 0, 10'($urandom_range(0, 1023)));

        // crash and start together in RUN: crash wins.
        drive(0, 1, 1, 10'd0);
        check("crashstart.run", 64'(a_run), 64'(0));
        drive(0, 1, 0, 10'd0);

        // Random control phase.
        for (int k = 0; k < 1500; k++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) == 0),
                  10'($urandom_range(0, 1023)));
        end

        // Asynchronous reset in the middle of a run, away from any clock edge.
        drive(0, 1, 0, 10'd0);
        repeat (20) drive(1, 0, 0, 10'($urandom_range(0, 1023)));
        drive(0, 0, 0, 10'd0);
        #1;
        rst_n = 1'b0;
        tick = 1'b0; start = 1'b0; crash = 1'b0;
        model_reset();
        #1;
        check_zero("async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(0, 1, 0, 10'd0);
        repeat (30) drive(1, 0, 0, 10'($urandom_range(0, 1023)));
        drive(0, 0, 0, 10'd0);

        check("sb.pending", 64'(q_a.size() + q_b.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
